// File: rtl/call_display_scanner_if.sv
// Ticket/call inputs and multiplexed 7-segment outputs shared by the
// call source (master) and the display scanner (slave).
interface call_display_scanner_if;
  logic [5:0] current_number;
  logic [5:0] number_service;
  logic [2:0] counter_call;
  logic [6:0] seg;
  logic [5:0] an;
  logic       busy_blink;

  modport master (
    output current_number, number_service, counter_call,
    input  seg, an, busy_blink
  );

  modport slave (
    input  current_number, number_service, counter_call,
    output seg, an, busy_blink
  );
endinterface

// File: rtl/call_display_scanner.sv
// Six-digit common-anode display scanner: [issued tt][letter][-][called tt].
// The call group blinks for a fixed burst whenever a new call arrives.
module call_display_scanner #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int BLINK_COUNT = 6
) (
  input logic clk,
  input logic rst,
  call_display_scanner_if.slave bus
);
  localparam int ScanW  = $clog2(SCAN_DIV);
  localparam int BlinkW = $clog2(BLINK_DIV);
  localparam int HalfW  = $clog2(BLINK_COUNT);

  typedef enum logic [1:0] {IDLE, BLK_OFF, BLK_ON} blink_state_e;

  logic [5:0]        capNum, capSvc, prevSvc;
  logic [2:0]        capCall, prevCall;
  logic [1:0]        validCnt;
  logic              callValid, evt;
  logic [ScanW-1:0]  scanCnt;
  logic [2:0]        scanIdx, idxNext;
  logic              scanTc;
  logic [3:0]        digitCode;
  logic [6:0]        segNext;
  blink_state_e      state, stateNext;
  logic [BlinkW-1:0] blinkCnt, blinkCntNext;
  logic [HalfW-1:0]  half, halfNext;

  function automatic logic [3:0] tensOf(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] onesOf(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // Codes 0-9 are digits, 10-14 are letters A-E, 15 is the dash.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      4'd10:   return 7'h08;
      4'd11:   return 7'h03;
      4'd12:   return 7'h46;
      4'd13:   return 7'h21;
      4'd14:   return 7'h06;
      default: return 7'h3F;
    endcase
  endfunction

  // Capture plus a one-cycle history; the detector arms after two real captures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capNum   <= '0;
      capSvc   <= '0;
      capCall  <= '0;
      prevSvc  <= '0;
      prevCall <= '0;
      validCnt <= '0;
    end else begin
      // NOTE: non-blocking, so prev* samples the capture value from before this edge.
      capNum   <= bus.current_number;
      capSvc   <= bus.number_service;
      capCall  <= bus.counter_call;
      prevSvc  <= capSvc;
      prevCall <= capCall;
      if (validCnt != 2'd2) validCnt <= validCnt + 2'd1;
    end
  end

  assign callValid = (capCall != 3'd0) && (capCall < 3'd6);
  assign evt       = (validCnt == 2'd2) && ({capCall, capSvc} != {prevCall, prevSvc}) && callValid;
  assign scanTc    = (scanCnt == ScanW'(SCAN_DIV - 1));
  assign idxNext   = !scanTc ? scanIdx : (scanIdx == 3'd5) ? 3'd0 : scanIdx + 3'd1;

  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    digitCode = 4'hF;
    case (idxNext)
      3'd5:    digitCode = tensOf(capNum);
      3'd4:    digitCode = onesOf(capNum);
      3'd3:    if (callValid) digitCode = 4'(capCall) + 4'd9;
      3'd1:    if (callValid) digitCode = tensOf(capSvc);
      3'd0:    if (callValid) digitCode = onesOf(capSvc);
      default: digitCode = 4'hF;
    endcase
    segNext = ((idxNext < 3'd4) && (state == BLK_OFF)) ? 7'h7F : glyph(digitCode);
  end

  // an and seg come from the same index on the same edge: no ghosting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scanCnt <= '0;
      scanIdx <= '0;
      bus.an  <= '1;
      bus.seg <= 7'h7F;
    end else begin
      scanCnt <= scanTc ? '0 : scanCnt + ScanW'(1);
      scanIdx <= idxNext;
      bus.an  <= ~(6'b1 << idxNext);
      bus.seg <= segNext;
    end
  end

  always_comb begin
    stateNext    = state;
    blinkCntNext = blinkCnt;
    halfNext     = half;
    if (evt) begin
      stateNext    = BLK_OFF;
      blinkCntNext = '0;
      halfNext     = '0;
    end else if (state != IDLE) begin
      if (blinkCnt == BlinkW'(BLINK_DIV - 1)) begin
        blinkCntNext = '0;
        if (half == HalfW'(BLINK_COUNT - 1)) begin
          stateNext = IDLE;
          halfNext  = '0;
        end else begin
          stateNext = (state == BLK_OFF) ? BLK_ON : BLK_OFF;
          halfNext  = half + HalfW'(1);
        end
      end else begin
        blinkCntNext = blinkCnt + BlinkW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      blinkCnt       <= '0;
      half           <= '0;
      bus.busy_blink <= 1'b0;
    end else begin
      state          <= stateNext;
      blinkCnt       <= blinkCntNext;
      half           <= halfNext;
      bus.busy_blink <= (stateNext != IDLE);
    end
  end
endmodule

// File: tb/tb_call_display_scanner.sv
// Randomized and directed bench for call_display_scanner with a
// burst-age reference model of the display and blink behaviour.
module tb_call_display_scanner;
  localparam int SD = 2;
  localparam int BD = 4;
  localparam int BC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passCnt = 0;
  int   totalCnt = 0;

  call_display_scanner_if bus ();

  call_display_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD), .BLINK_COUNT(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] digGly [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] letGly [5]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06};

  // Model: n = edges since release; m1/m2 = inputs seen one/two edges back.
  int n, age, m1Num, m1Svc, m1Call, m2Svc, m2Call, dNum, dSvc, dCall;
  bit active;
  logic [5:0] expAn;
  logic [6:0] expSeg;
  bit expBusy;

  function automatic logic [6:0] refGlyph(int idx, int num, int svc, int call, bit blank);
    bit has;
    has = (call >= 1) && (call <= 5);
    if (blank && idx < 4) return 7'h7F;
    case (idx)
      5: return digGly[num / 10];
      4: return digGly[num % 10];
      3: return has ? letGly[call - 1] : 7'h3F;
      1: return has ? digGly[svc / 10] : 7'h3F;
      0: return has ? digGly[svc % 10] : 7'h3F;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic setIn(int num, int svc, int call);
    dNum = num; dSvc = svc; dCall = call;
    bus.current_number = 6'(num);
    bus.number_service = 6'(svc);
    bus.counter_call   = 3'(call);
  endtask

  task automatic tick();
    bit evt, blankPrev;
    int idx;
    @(posedge clk);
    n++;
    idx = (n / SD) % 6;
    evt = (n >= 3) && (m1Call != m2Call || m1Svc != m2Svc) && m1Call >= 1 && m1Call <= 5;
    blankPrev = active && ((age / BD) % 2 == 0);
    expAn  = ~(6'b1 << idx);
    expSeg = refGlyph(idx, m1Num, m1Svc, m1Call, blankPrev);
    if (evt) begin
      active = 1; age = 0;
    end else if (active) begin
      age++;
      if (age == BC * BD) active = 0;
    end
    expBusy = active;
    m2Svc = m1Svc; m2Call = m1Call;
    m1Num = dNum; m1Svc = dSvc; m1Call = dCall;
    @(negedge clk);
  endtask

  task automatic doReset(int num, int svc, int call);
    @(negedge clk);
    rst = 1'b0;
    setIn(num, svc, call);
    n = 0; age = 0; active = 0;
    m1Num = 0; m1Svc = 0; m1Call = 0; m2Svc = 0; m2Call = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    setIn(37, 5, 3);
    repeat (3) @(negedge clk);
    totalCnt++; if (bus.an !== 6'h3F) $display("FAIL reset_an got=%b exp=%b", bus.an, 6'h3F); else passCnt++;
    totalCnt++; if (bus.seg !== 7'h7F) $display("FAIL reset_seg got=%h exp=%h", bus.seg, 7'h7F); else passCnt++;
    totalCnt++; if (bus.busy_blink !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy_blink); else passCnt++;
    doReset(37, 5, 3);
    tick();
    totalCnt++; if (bus.an !== 6'b111110) $display("FAIL release_an got=%b exp=111110", bus.an); else passCnt++;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    totalCnt++; if (bus.an !== 6'h3F) $display("FAIL async_an got=%b exp=%b", bus.an, 6'h3F); else passCnt++;
    totalCnt++; if (bus.seg !== 7'h7F) $display("FAIL async_seg got=%h exp=%h", bus.seg, 7'h7F); else passCnt++;
  endtask

  task automatic test_scan_order();
    doReset(12, 0, 0);
    for (int i = 0; i < 14; i++) begin
      tick();
      totalCnt++; if (bus.an !== expAn) $display("FAIL scan_an cyc=%0d got=%b exp=%b", n, bus.an, expAn); else passCnt++;
      totalCnt++;
      if ($countones(~bus.an) != 1) $display("FAIL scan_onehot cyc=%0d got=%b exp=one low bit", n, bus.an);
      else passCnt++;
    end
  endtask

  task automatic test_decode(int num, int svc, int call, logic [6:0] t0, logic [6:0] t1, logic [6:0] t2,
                             logic [6:0] t3, logic [6:0] t4, logic [6:0] t5);
    logic [6:0] tbl [6];
    int idx;
    tbl = '{t0, t1, t2, t3, t4, t5};
    doReset(num, svc, call);
    for (int i = 0; i < 14; i++) begin
      tick();
      idx = (n / SD) % 6;
      totalCnt++; if (bus.seg !== expSeg) $display("FAIL decode_model cyc=%0d got=%h exp=%h", n, bus.seg, expSeg); else passCnt++;
      if (n >= 2) begin
        totalCnt++;
        if (bus.seg !== tbl[idx]) $display("FAIL decode_digit%0d got=%h exp=%h", idx, bus.seg, tbl[idx]);
        else passCnt++;
      end
    end
  endtask

  task automatic test_blink();
    int waitC, highC;
    doReset(10, 5, 3);
    repeat (4) tick();
    setIn(10, 6, 3);
    waitC = 0;
    do begin tick(); waitC++; end while (!bus.busy_blink && waitC < 10);
    totalCnt++; if (waitC != 2) $display("FAIL blink_latency got=%0d exp=2", waitC); else passCnt++;
    highC = 0;
    while (bus.busy_blink && highC < 40) begin
      tick();
      highC++;
      totalCnt++; if (bus.seg !== expSeg) $display("FAIL blink_seg cyc=%0d got=%h exp=%h", n, bus.seg, expSeg); else passCnt++;
      if (!bus.an[5] || !bus.an[4]) begin
        totalCnt++;
        if (bus.seg === 7'h7F) $display("FAIL blink_upper an=%b got=%h exp=not 7F", bus.an, bus.seg);
        else passCnt++;
      end
    end
    totalCnt++; if (highC != BC * BD) $display("FAIL blink_length got=%0d exp=%0d", highC, BC * BD); else passCnt++;
  endtask

  task automatic test_restart_ignore();
    int cnt;
    doReset(20, 5, 1);
    repeat (4) tick();
    setIn(20, 9, 1);
    repeat (10) tick();
    setIn(20, 9, 2);
    cnt = 0;
    do begin
      tick(); cnt++;
      totalCnt++; if (bus.seg !== expSeg) $display("FAIL restart_seg cyc=%0d got=%h exp=%h", n, bus.seg, expSeg); else passCnt++;
    end while (bus.busy_blink && cnt < 40);
    totalCnt++; if (cnt != 2 + BC * BD) $display("FAIL restart_length got=%0d exp=%0d", cnt, 2 + BC * BD); else passCnt++;
    for (int k = 0; k < 2; k++) begin
      setIn(20, 15 + k, (k == 0) ? 0 : 7);
      for (int i = 0; i < 16; i++) begin
        tick();
        totalCnt++; if (bus.busy_blink !== 1'b0) $display("FAIL ignore_busy call=%0d got=%b exp=0", dCall, bus.busy_blink); else passCnt++;
        if (i >= 2 && bus.an[3:0] != 4'hF) begin
          totalCnt++;
          if (bus.seg !== 7'h3F) $display("FAIL ignore_dash call=%0d got=%h exp=3f", dCall, bus.seg);
          else passCnt++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    doReset(1, 2, 4);
    repeat (4) tick();
    setIn(1, 3, 4);
    repeat (8) tick();
    totalCnt++; if (bus.busy_blink !== expBusy) $display("FAIL midburst_pre got=%b exp=%b", bus.busy_blink, expBusy); else passCnt++;
    #2 rst = 1'b0;
    #1;
    totalCnt++; if (bus.busy_blink !== 1'b0) $display("FAIL midburst_busy got=%b exp=0", bus.busy_blink); else passCnt++;
    totalCnt++; if (bus.seg !== 7'h7F) $display("FAIL midburst_seg got=%h exp=7f", bus.seg); else passCnt++;
    doReset(1, 3, 4);
    for (int i = 0; i < 30; i++) begin
      tick();
      totalCnt++; if (bus.busy_blink !== 1'b0) $display("FAIL rearm_busy cyc=%0d got=%b exp=0", n, bus.busy_blink); else passCnt++;
    end
  endtask

  task automatic test_random();
    doReset($urandom_range(63), $urandom_range(63), $urandom_range(7));
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(24) == 0)
        setIn($urandom_range(63), $urandom_range(63), $urandom_range(7));
      tick();
      totalCnt++; if (bus.an !== expAn) $display("FAIL rand_an cyc=%0d got=%b exp=%b", n, bus.an, expAn); else passCnt++;
      totalCnt++; if (bus.seg !== expSeg) $display("FAIL rand_seg cyc=%0d got=%h exp=%h", n, bus.seg, expSeg); else passCnt++;
      totalCnt++; if (bus.busy_blink !== expBusy) $display("FAIL rand_busy cyc=%0d got=%b exp=%b", n, bus.busy_blink, expBusy); else passCnt++;
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_decode(37, 5, 3, 7'h12, 7'h40, 7'h3F, 7'h46, 7'h78, 7'h30);
    test_decode(8, 63, 5, 7'h30, 7'h02, 7'h3F, 7'h06, 7'h00, 7'h40);
    test_blink();
    test_restart_ignore();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
